// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch side, the data side and the shared memory port.
// Handshake: a side's request (IMEM_READ, DMEM_READ[3] | DMEM_WRITE[2]) is its valid and must stay high until a clock edge where its busywait is low; that edge completes the transfer.
interface mem_arbiter_if;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;

  logic [3:0]  DMEM_READ;
  logic [2:0]  DMEM_WRITE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WRITEDATA;
  logic [31:0] DMEM_READDATA;
  logic        DMEM_BUSYWAIT;

  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  // Arbiter view.
  modport slave (
    input  IMEM_READ, IMEM_ADDR, DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output IMEM_READDATA, IMEM_BUSYWAIT, DMEM_READDATA, DMEM_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
  );

  // Environment view: both requesters plus the memory.
  modport master (
    output IMEM_READ, IMEM_ADDR, DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  IMEM_READDATA, IMEM_BUSYWAIT, DMEM_READDATA, DMEM_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data) onto one memory port with
// alternating priority on contention and a per-grant busywait timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus,
  output logic          ERROR,
  output logic [1:0]    o_dbg_state,
  output logic          o_dbg_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [7:0] LP_WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_last;      // 0 = fetch side served last, 1 = data side
  logic [7:0] r_waitcnt;
  logic       r_error;

  logic w_i_req;
  logic w_d_req;
  logic w_in_gnt_i;
  logic w_in_gnt_d;
  logic w_granted;
  logic w_timeout;
  logic w_complete;

  assign w_i_req    = bus.IMEM_READ;
  assign w_d_req    = bus.DMEM_READ[3] | bus.DMEM_WRITE[2];
  assign w_in_gnt_i = (r_state == GNT_I);
  assign w_in_gnt_d = (r_state == GNT_D);
  assign w_granted  = (w_in_gnt_i & w_i_req) | (w_in_gnt_d & w_d_req);
  assign w_timeout  = bus.MEM_BUSYWAIT & (r_waitcnt == LP_WAIT_LIMIT);
  assign w_complete = w_granted & (~bus.MEM_BUSYWAIT | w_timeout);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_last    <= 1'b0;
      r_waitcnt <= 8'd0;
      r_error   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_waitcnt <= 8'd0;
          if (w_i_req && w_d_req) begin
            r_state <= r_last ? GNT_I : GNT_D;
          end else if (w_i_req) begin
            r_state <= GNT_I;
          end else if (w_d_req) begin
            r_state <= GNT_D;
          end
        end
        GNT_I: begin
          if (!w_i_req) begin
            r_state   <= IDLE;
            r_waitcnt <= 8'd0;
          end else if (w_complete) begin
            r_last    <= 1'b0;
            r_state   <= w_d_req ? GNT_D : IDLE;
            r_waitcnt <= 8'd0;
            if (w_timeout) r_error <= 1'b1;
          end else if (bus.MEM_BUSYWAIT) begin
            r_waitcnt <= r_waitcnt + 8'd1;
          end
        end
        GNT_D: begin
          if (!w_d_req) begin
            r_state   <= IDLE;
            r_waitcnt <= 8'd0;
          end else if (w_complete) begin
            r_last    <= 1'b1;
            r_state   <= w_i_req ? GNT_I : IDLE;
            r_waitcnt <= 8'd0;
            if (w_timeout) r_error <= 1'b1;
          end else if (bus.MEM_BUSYWAIT) begin
            r_waitcnt <= r_waitcnt + 8'd1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_waitcnt <= 8'd0;
        end
      endcase
    end
  end

  // The memory port is a pure mux of the granted side; nothing is registered.
  always_comb begin
    bus.MEM_READ      = 4'b0000;
    bus.MEM_WRITE     = 3'b000;
    bus.MEM_ADDR      = 32'h0;
    bus.MEM_WRITEDATA = 32'h0;
    if (w_in_gnt_i) begin
      bus.MEM_READ = 4'b1010;
      bus.MEM_ADDR = bus.IMEM_ADDR;
    end else if (w_in_gnt_d) begin
      bus.MEM_READ      = bus.DMEM_READ;
      bus.MEM_WRITE     = bus.DMEM_WRITE;
      bus.MEM_ADDR      = bus.DMEM_ADDR;
      bus.MEM_WRITEDATA = bus.DMEM_WRITEDATA;
    end
  end

  assign bus.IMEM_BUSYWAIT = w_i_req & ~(w_in_gnt_i & w_complete);
  assign bus.DMEM_BUSYWAIT = w_d_req & ~(w_in_gnt_d & w_complete);

  // A timed-out transfer hands back zero instead of whatever the stuck memory shows.
  assign bus.IMEM_READDATA = (w_in_gnt_i & w_complete & w_timeout) ? 32'h0 : bus.MEM_READDATA;
  assign bus.DMEM_READDATA = (w_in_gnt_d & w_complete & w_timeout) ? 32'h0 : bus.MEM_READDATA;

  assign ERROR       = r_error;
  assign o_dbg_state = r_state;
  assign o_dbg_last  = r_last;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a
// transaction-level model of who owns the memory port and for how long.
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       error;
  logic [1:0] dbg_state;
  logic       dbg_last;

  int n_cmp = 0;
  int n_mis = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK         (clk),
    .RESET       (rst),
    .bus         (bus.slave),
    .ERROR       (error),
    .o_dbg_state (dbg_state),
    .o_dbg_last  (dbg_last)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Random-phase model variables: owner 0 none / 1 fetch / 2 data.
  int          m_owner;
  int          m_last;
  int          m_wait;
  int          other;
  logic        i_pend, d_pend;
  logic [31:0] i_addr, d_addr, d_wdata, rdata;
  logic [3:0]  d_rd;
  logic [2:0]  d_wr;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_rd;
  logic [2:0]  exp_wr;

  initial begin
    rst = 1'b1;
    bus.IMEM_READ = 1'b0;      bus.IMEM_ADDR = 32'h0;
    bus.DMEM_READ = 4'b0;      bus.DMEM_WRITE = 3'b0;
    bus.DMEM_ADDR = 32'h0;     bus.DMEM_WRITEDATA = 32'h0;
    bus.MEM_READDATA = 32'h0;  bus.MEM_BUSYWAIT = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_last", 32'(dbg_last), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
    chk("rst_mem_addr", bus.MEM_ADDR, 32'd0);
    chk("rst_dbusy", 32'(bus.DMEM_BUSYWAIT), 32'd0);
    bus.IMEM_READ = 1'b1;
    #1;
    chk("rst_ibusy_follows_req", 32'(bus.IMEM_BUSYWAIT), 32'd1);
    bus.IMEM_READ = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single fetch, zero-wait memory
    @(negedge clk);
    bus.IMEM_READ = 1'b1; bus.IMEM_ADDR = 32'h40; bus.MEM_READDATA = 32'h00001237;
    #1;
    chk("f_idle_ibusy", 32'(bus.IMEM_BUSYWAIT), 32'd1);
    chk("f_idle_mem_read", 32'(bus.MEM_READ), 32'd0);
    @(negedge clk); #1;
    chk("f_mem_read", 32'(bus.MEM_READ), 32'hA);
    chk("f_mem_addr", bus.MEM_ADDR, 32'h40);
    chk("f_ibusy", 32'(bus.IMEM_BUSYWAIT), 32'd0);
    chk("f_rdata", bus.IMEM_READDATA, 32'h00001237);
    @(negedge clk);
    bus.IMEM_READ = 1'b0;
    #1;
    chk("f_back_idle", 32'(dbg_state), 32'd0);
    chk("f_last", 32'(dbg_last), 32'd0);

    // Simultaneous fetch and store right after reset: data side first
    rst = 1'b1; #1; rst = 1'b0;
    bus.IMEM_READ = 1'b1; bus.IMEM_ADDR = 32'h80;
    bus.DMEM_WRITE = 3'b110; bus.DMEM_ADDR = 32'h100; bus.DMEM_WRITEDATA = 32'hDEADBEEF;
    #1;
    chk("s_idle_ibusy", 32'(bus.IMEM_BUSYWAIT), 32'd1);
    chk("s_idle_dbusy", 32'(bus.DMEM_BUSYWAIT), 32'd1);
    @(negedge clk);
    bus.MEM_BUSYWAIT = 1'b1;
    #1;
    chk("s_gnt_d", 32'(dbg_state), 32'd2);
    chk("s_mem_write", 32'(bus.MEM_WRITE), 32'h6);
    chk("s_mem_addr", bus.MEM_ADDR, 32'h100);
    chk("s_mem_wdata", bus.MEM_WRITEDATA, 32'hDEADBEEF);
    chk("s_dbusy_wait", 32'(bus.DMEM_BUSYWAIT), 32'd1);
    chk("s_ibusy_wait", 32'(bus.IMEM_BUSYWAIT), 32'd1);
    @(negedge clk);
    bus.MEM_BUSYWAIT = 1'b0;
    #1;
    chk("s_dbusy_done", 32'(bus.DMEM_BUSYWAIT), 32'd0);
    chk("s_ibusy_done", 32'(bus.IMEM_BUSYWAIT), 32'd1);
    @(negedge clk);
    bus.DMEM_WRITE = 3'b000;
    #1;
    chk("s_gnt_i_b2b", 32'(dbg_state), 32'd1);
    chk("s_i_mem_read", 32'(bus.MEM_READ), 32'hA);
    chk("s_i_mem_addr", bus.MEM_ADDR, 32'h80);
    chk("s_i_mem_write", 32'(bus.MEM_WRITE), 32'd0);
    chk("s_i_ibusy", 32'(bus.IMEM_BUSYWAIT), 32'd0);
    @(negedge clk);
    bus.IMEM_READ = 1'b0;
    #1;
    chk("s_idle", 32'(dbg_state), 32'd0);

    // Continuous contention: D,I,D,I,D,I
    bus.IMEM_READ = 1'b1; bus.IMEM_ADDR = 32'h200;
    bus.DMEM_READ = 4'b1010; bus.DMEM_ADDR = 32'h300;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk("alt_addr", bus.MEM_ADDR, (k % 2 == 0) ? 32'h300 : 32'h200);
    end
    @(negedge clk);
    bus.IMEM_READ = 1'b0; bus.DMEM_READ = 4'b0;
    @(negedge clk); #1;
    chk("alt_idle", 32'(dbg_state), 32'd0);
    chk("alt_last_unchanged", 32'(dbg_last), 32'd0);

    // Data request withdrawn mid-grant, pending fetch then served
    bus.IMEM_READ = 1'b1; bus.IMEM_ADDR = 32'h500;
    bus.DMEM_READ = 4'b1100; bus.DMEM_ADDR = 32'h600;
    @(negedge clk);
    bus.MEM_BUSYWAIT = 1'b1;
    #1;
    chk("w_gnt_d", 32'(dbg_state), 32'd2);
    chk("w_mem_read", 32'(bus.MEM_READ), 32'hC);
    chk("w_mem_addr", bus.MEM_ADDR, 32'h600);
    @(negedge clk);
    bus.DMEM_READ = 4'b0;
    #1;
    chk("w_dbusy_dropped", 32'(bus.DMEM_BUSYWAIT), 32'd0);
    chk("w_ibusy_pending", 32'(bus.IMEM_BUSYWAIT), 32'd1);
    @(negedge clk);
    bus.MEM_BUSYWAIT = 1'b0;
    #1;
    chk("w_idle", 32'(dbg_state), 32'd0);
    chk("w_last", 32'(dbg_last), 32'd0);
    chk("w_no_error", 32'(error), 32'd0);
    @(negedge clk); #1;
    chk("w_gnt_i", 32'(dbg_state), 32'd1);
    chk("w_i_addr", bus.MEM_ADDR, 32'h500);
    chk("w_i_ibusy", 32'(bus.IMEM_BUSYWAIT), 32'd0);
    @(negedge clk);
    bus.IMEM_READ = 1'b0;

    // Timeout on a load with memory stuck busy
    bus.DMEM_READ = 4'b1010; bus.DMEM_ADDR = 32'h700; bus.MEM_READDATA = 32'hCAFEF00D;
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      bus.MEM_BUSYWAIT = 1'b1;
      #1;
      if (b < 4) begin
        chk("to_dbusy_wait", 32'(bus.DMEM_BUSYWAIT), 32'd1);
      end else begin
        chk("to_dbusy_done", 32'(bus.DMEM_BUSYWAIT), 32'd0);
        chk("to_rdata_zero", bus.DMEM_READDATA, 32'h0);
        chk("to_error_pre", 32'(error), 32'd0);
      end
    end
    @(negedge clk);
    bus.DMEM_READ = 4'b0; bus.MEM_BUSYWAIT = 1'b0;
    #1;
    chk("to_error_set", 32'(error), 32'd1);
    chk("to_idle", 32'(dbg_state), 32'd0);
    bus.IMEM_READ = 1'b1; bus.IMEM_ADDR = 32'h44; bus.MEM_READDATA = 32'h55;
    @(negedge clk); #1;
    chk("to_good_rdata", bus.IMEM_READDATA, 32'h55);
    @(negedge clk);
    bus.IMEM_READ = 1'b0;
    #1;
    chk("to_error_sticky", 32'(error), 32'd1);

    // Reset during a busy fetch
    bus.IMEM_READ = 1'b1; bus.IMEM_ADDR = 32'h48;
    @(negedge clk);
    bus.MEM_BUSYWAIT = 1'b1;
    #1;
    chk("r_gnt_i", 32'(dbg_state), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("r_state_idle", 32'(dbg_state), 32'd0);
    chk("r_mem_read", 32'(bus.MEM_READ), 32'd0);
    chk("r_error_clr", 32'(error), 32'd0);
    chk("r_last", 32'(dbg_last), 32'd0);
    chk("r_ibusy", 32'(bus.IMEM_BUSYWAIT), 32'd1);
    @(negedge clk);
    rst = 1'b0; bus.IMEM_READ = 1'b0; bus.MEM_BUSYWAIT = 1'b0;

    // Randomized traffic against the ownership model
    m_owner = 0; m_last = 0; m_wait = 0;
    i_pend = 1'b0; d_pend = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_rd = 4'b0; d_wr = 3'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1;
        i_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend  = 1'b1;
        d_addr  = $urandom;
        d_wdata = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          d_rd = {1'b1, 3'($urandom_range(0, 7))};
          d_wr = 3'b000;
        end else begin
          d_rd = 4'b0000;
          d_wr = {1'b1, 2'($urandom_range(0, 3))};
        end
      end
      rdata = $urandom;
      bus.IMEM_READ      = i_pend;
      bus.IMEM_ADDR      = i_addr;
      bus.DMEM_READ      = d_pend ? d_rd : 4'b0;
      bus.DMEM_WRITE     = d_pend ? d_wr : 3'b0;
      bus.DMEM_ADDR      = d_addr;
      bus.DMEM_WRITEDATA = d_wdata;
      bus.MEM_READDATA   = rdata;
      bus.MEM_BUSYWAIT   = (m_owner != 0) && (m_wait > 0);
      #1;
      exp_rd = 4'b0; exp_wr = 3'b0; exp_addr = 32'h0; exp_wdata = 32'h0;
      if (m_owner == 1) begin
        exp_rd = 4'b1010; exp_addr = i_addr;
      end else if (m_owner == 2) begin
        exp_rd = d_rd; exp_wr = d_wr; exp_addr = d_addr; exp_wdata = d_wdata;
      end
      chk("rnd_mem_read", 32'(bus.MEM_READ), 32'(exp_rd));
      chk("rnd_mem_write", 32'(bus.MEM_WRITE), 32'(exp_wr));
      chk("rnd_mem_addr", bus.MEM_ADDR, exp_addr);
      chk("rnd_mem_wdata", bus.MEM_WRITEDATA, exp_wdata);
      chk("rnd_ibusy", 32'(bus.IMEM_BUSYWAIT), 32'(i_pend && !(m_owner == 1 && m_wait == 0)));
      chk("rnd_dbusy", 32'(bus.DMEM_BUSYWAIT), 32'(d_pend && !(m_owner == 2 && m_wait == 0)));
      if (m_owner == 1 && m_wait == 0) chk("rnd_i_rdata", bus.IMEM_READDATA, rdata);
      if (m_owner == 2 && m_wait == 0) chk("rnd_d_rdata", bus.DMEM_READDATA, rdata);
      // What the coming clock edge does to ownership.
      if (m_owner != 0) begin
        if (m_wait == 0) begin
          if (m_owner == 1) i_pend = 1'b0; else d_pend = 1'b0;
          m_last  = (m_owner == 2) ? 1 : 0;
          other   = (m_owner == 1) ? int'(d_pend) : int'(i_pend);
          m_owner = (other != 0) ? 3 - m_owner : 0;
          m_wait  = $urandom_range(0, 2);
        end else begin
          m_wait--;
        end
      end else if (i_pend || d_pend) begin
        if (i_pend && d_pend) m_owner = (m_last == 1) ? 1 : 2;
        else m_owner = i_pend ? 1 : 2;
        m_wait = $urandom_range(0, 2);
      end
    end
    @(negedge clk);
    bus.IMEM_READ = 1'b0; bus.DMEM_READ = 4'b0; bus.DMEM_WRITE = 3'b0; bus.MEM_BUSYWAIT = 1'b0;
    #1;
    chk("rnd_no_error", 32'(error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock, CLK; reset is RESET, asynchronous and active-high.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the max consecutive MEM_BUSYWAIT-high cycles in one grant before abort (range 1..255, 8-bit counter).
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RESET  in  1  async active-high reset.
REQ-005 IMEM_READ  in  1  instruction fetch request.
REQ-006 IMEM_ADDR  in  32  fetch address.
REQ-007 IMEM_READDATA  out  32  fetched word.
REQ-008 IMEM_BUSYWAIT  out  1  stall to fetch side.
REQ-009 DMEM_READ  in  4  [3]=valid, [2:0]=load type.
REQ-010 DMEM_WRITE  in  3  [2]=valid, [1:0]=store size.
REQ-011 DMEM_ADDR  in  32; DMEM_WRITEDATA  in  32; DMEM_READDATA  out  32.
REQ-012 DMEM_BUSYWAIT  out  1  stall to data side.
REQ-013 MEM_READ  out  4; MEM_WRITE  out  3; MEM_ADDR  out  32; MEM_WRITEDATA  out  32  shared memory port, same encodings.
REQ-014 MEM_READDATA  in  32; MEM_BUSYWAIT  in  1  (memory asserts combinationally in the cycle a request appears).
REQ-015 ERROR  out  1  sticky timeout flag.

Function
REQ-016 I_REQ = IMEM_READ; D_REQ = DMEM_READ[3] | DMEM_WRITE[2].
REQ-017 FSM states: IDLE, GNT_I, GNT_D; registers LAST (I/D) and WAITCNT (8 bits).
REQ-018 IDLE: only I_REQ -> GNT_I; only D_REQ -> GNT_D; both -> GNT_D if LAST=I, else GNT_I; none -> stay.
REQ-019 IDLE: MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WRITEDATA=0.
REQ-020 GNT_I: MEM_READ=4'b1010 (word), MEM_WRITE=0, MEM_ADDR=IMEM_ADDR, MEM_WRITEDATA=0, combinational from inputs.
REQ-021 GNT_D: MEM_READ=DMEM_READ, MEM_WRITE=DMEM_WRITE, MEM_ADDR=DMEM_ADDR, MEM_WRITEDATA=DMEM_WRITEDATA, combinational.
REQ-022 Completion = granted state, requester still requesting, and (MEM_BUSYWAIT=0 or timeout).
REQ-023 Timeout = MEM_BUSYWAIT=1 and WAITCNT=TIMEOUT-1; WAITCNT increments each granted cycle with MEM_BUSYWAIT=1, clears on every state change.
REQ-024 On completion edge: LAST := granted side; next state = other side's grant if other side requests, else IDLE.
REQ-025 Granted requester drops its request before completion -> IDLE next edge, LAST unchanged, no error.
REQ-026 IMEM_BUSYWAIT = I_REQ & ~(GNT_I & completion); DMEM_BUSYWAIT = D_REQ & ~(GNT_D & completion); both 0 when not requesting.
REQ-027 IMEM_READDATA, DMEM_READDATA = MEM_READDATA in normal completion; 32'h0 in a timeout completion cycle.
REQ-028 Timeout completion SHALL set ERROR=1, held until RESET.
REQ-029 Minimum latency: request seen in IDLE at edge N -> grant at N, completion at edge N+1 with zero-wait memory.
REQ-030 Request arriving during other side's grant waits; served immediately after that completion with no IDLE bubble.

Reset
REQ-031 RESET=1 SHALL force, asynchronously: state=IDLE, LAST=I, WAITCNT=0, ERROR=0; outputs per REQ-019/026 (busywaits follow requests).
REQ-032 RESET mid-grant SHALL abandon the transfer; no completion is signalled for it.

Verification
REQ-033 Fetch only, zero-wait memory, IMEM_ADDR=0x40, MEM_READDATA=0x00001237 -> MEM_READ=1010/MEM_ADDR=0x40 one cycle after request; IMEM_BUSYWAIT low that cycle; IMEM_READDATA=0x00001237.
REQ-034 Simultaneous I_REQ and store (DMEM_WRITE=3'b110, addr 0x100, data 0xDEADBEEF) after reset -> GNT_D first with MEM_WRITE=110, then GNT_I back-to-back; IMEM_BUSYWAIT high throughout GNT_D.
REQ-035 Both requesting continuously for 6 transfers -> grants alternate D,I,D,I,D,I.
REQ-036 TIMEOUT=4, MEM_BUSYWAIT stuck high on load -> completion on 4th busy cycle, DMEM_READDATA=0, ERROR=1 and stays 1 on later good transfers.
REQ-037 Memory busy 3 cycles on fetch, RESET pulsed on 2nd -> state IDLE, MEM_READ=0 immediately, ERROR=0, LAST=I.
REQ-038 DMEM_READ drops mid-GNT_D -> IDLE next edge; pending I_REQ then granted.
